// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetcher: issues sequential word fetches, one in flight at a time,
// and buffers {address, data} pairs in a DEPTH-entry FIFO for the decode stage.
module instruction_prefetch_queue #(
    parameter int ADDR_W    = 32,
    parameter int INSTR_W   = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
    logic [INSTR_W-1:0]  data_mem_q [DEPTH];

    logic hs, push, pop;

    assign mem_req_valid = (state_q == REQ) && (count_q < CW'(DEPTH));
    assign mem_req_addr  = fetch_addr_q;
    assign instr_valid   = (count_q != '0);
    // Storage is not reset; gating keeps the head outputs at zero while empty.
    assign instr         = instr_valid ? data_mem_q[rd_ptr_q] : '0;
    assign instr_addr    = instr_valid ? addr_mem_q[rd_ptr_q] : '0;

    assign hs   = mem_req_valid & mem_req_ready;
    assign push = (state_q == WAIT) & mem_rsp_valid & ~redirect;
    assign pop  = instr_valid & instr_ready & ~redirect;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (redirect) begin
            fetch_addr_d = redirect_addr;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            // A request already in flight must have its response swallowed.
            case (state_q)
                WAIT:    state_d = mem_rsp_valid ? REQ : DROP;
                DROP:    state_d = mem_rsp_valid ? REQ : DROP;
                REQ:     state_d = hs ? DROP : REQ;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: if (hs) begin
                    req_addr_d   = fetch_addr_q;
                    fetch_addr_d = fetch_addr_q + ADDR_W'(ADDR_STEP);
                    state_d      = WAIT;
                end
                WAIT:    if (mem_rsp_valid) state_d = REQ;
                DROP:    if (mem_rsp_valid) state_d = REQ;
                default: state_d = state_q;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            req_addr_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            addr_mem_q[wr_ptr_q] <= req_addr_q;
            data_mem_q[wr_ptr_q] <= mem_rsp_data;
        end
    end

endmodule
